// File: rtl/cache_controller_v2_if.sv
// SPI memory bus between the cache controller and the external memory port.
// The controller is the master: it presents an address (and store data on
// writes), the memory answers with spi_ready once per accepted/returned word.
interface cache_controller_v2_if;
   logic [31:0] spi_fetch;
   logic        spi_ready;
   logic        spi_addr_valid;
   logic        spi_write;
   logic [31:0] spi_address;
   logic [31:0] spi_store;
   logic [3:0]  write_strobe;

   modport master (
      input  spi_fetch, spi_ready,
      output spi_addr_valid, spi_write, spi_address, spi_store, write_strobe
   );

   modport slave (
      output spi_fetch, spi_ready,
      input  spi_addr_valid, spi_write, spi_address, spi_store, write_strobe
   );
endinterface

// File: rtl/cache_controller_v2.sv
// Page-granular cache refill controller.
// Holds the core clock while an I-slice page or a D-cache way is refilled
// over SPI. D-way victims are picked round-robin among unlocked ways; dirty
// victims are written back before the new page is fetched. Each completed
// page ends with a base write followed by a bound write for the target slice.
module cache_controller_v2 #(
   parameter int NUM_D_WAYS = 4,
   parameter int PAGE_WORDS = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               pc_fetch,
   input  logic [31:0]               data_address,
   input  logic                      i_miss,
   input  logic [NUM_D_WAYS-1:0]     d_miss,
   input  logic                      d_access,
   input  logic [NUM_D_WAYS-1:0]     d_dirty,
   input  logic [NUM_D_WAYS-1:0]     d_lock,
   input  logic [32*NUM_D_WAYS-1:0]  d_way_base,
   input  logic [31:0]               wb_data,
   cache_controller_v2_if.master     spi,
   output logic [31:0]               refill_data,
   output logic [31:0]               refill_addr,
   output logic                      i_refill_en,
   output logic [NUM_D_WAYS-1:0]     d_refill_en,
   output logic [NUM_D_WAYS-1:0]     wb_sel,
   output logic [31:0]               base_buffer,
   output logic [31:0]               bound_buffer,
   output logic                      i_base_we,
   output logic                      i_bound_we,
   output logic [NUM_D_WAYS-1:0]     d_base_we,
   output logic [NUM_D_WAYS-1:0]     d_bound_we,
   output logic                      set_clk_enable,
   output logic                      busy,
   output logic                      err_all_locked
);

   localparam int OFF_W = $clog2(PAGE_WORDS) + 2;
   localparam int CNT_W = $clog2(PAGE_WORDS);
   localparam int VW    = (NUM_D_WAYS > 1) ? $clog2(NUM_D_WAYS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(PAGE_WORDS - 1);
   localparam logic [VW-1:0]    LAST_WAY   = VW'(NUM_D_WAYS - 1);
   localparam logic [31:0]      PAGE_BYTES = 32'(PAGE_WORDS * 4);

   typedef enum logic [2:0] {
      S_POR,
      S_IDLE,
      S_SEL,
      S_WRBK,
      S_FETCH,
      S_UPD_BASE,
      S_UPD_BOUND
   } state_t;

   state_t          state, state_nx;
   logic [CNT_W-1:0] word_cnt;
   logic [VW-1:0]   rr_ptr;
   logic [VW-1:0]   victim;
   logic            target_d;      // 0: I-slice, 1: D-cache way 'victim'
   logic [31:0]     wb_base;       // resident page of the victim, captured in SEL
   logic            refill_pulse;  // one word landed last cycle

   logic [VW-1:0]   sel_victim;
   logic            sel_found;
   int              cand;
   logic [NUM_D_WAYS-1:0] victim_oh;
   logic [31:0]     word_off;
   logic [31:0]     fetch_addr;
   logic [31:0]     wb_addr;
   logic            xfer_step;
   logic            xfer_last;

   // Low address bits fall inside the page and are dropped when forming bases.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{pc_fetch[OFF_W-1:0], data_address[OFF_W-1:0]};

   function automatic logic [31:0] page_base(input logic [31:0] addr);
      return {addr[31:OFF_W], {OFF_W{1'b0}}};
   endfunction

   assign word_off     = {{(32-CNT_W-2){1'b0}}, word_cnt, 2'b00};
   assign fetch_addr   = base_buffer + word_off;
   assign wb_addr      = wb_base + word_off;
   assign bound_buffer = base_buffer + PAGE_BYTES;
   assign xfer_step    = ((state == S_WRBK) || (state == S_FETCH)) && spi.spi_ready;
   assign xfer_last    = xfer_step && (word_cnt == LAST_WORD);

   assign i_refill_en  = refill_pulse && !target_d;
   assign d_refill_en  = (refill_pulse && target_d) ? victim_oh : '0;

   // One-hot decode of the registered victim way.
   always_comb begin
      victim_oh         = '0;
      victim_oh[victim] = 1'b1;
   end

   // Victim search: first unlocked way at or after rr_ptr, wrapping around.
   always_comb begin
      sel_victim = rr_ptr;
      sel_found  = 1'b0;
      cand       = 0;
      for (int i = 0; i < NUM_D_WAYS; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_D_WAYS) cand = cand - NUM_D_WAYS;
         if (!sel_found && !d_lock[cand]) begin
            sel_found  = 1'b1;
            sel_victim = VW'(cand);
         end
      end
   end

   // Next-state decode and per-state bus/strobe outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned; a missed default here would infer a latch.
      state_nx           = state;
      set_clk_enable     = 1'b0;
      busy               = 1'b1;
      spi.spi_addr_valid = 1'b0;
      spi.spi_write      = 1'b0;
      spi.spi_address    = '0;
      spi.spi_store      = '0;
      spi.write_strobe   = 4'h0;
      wb_sel             = '0;
      i_base_we          = 1'b0;
      i_bound_we         = 1'b0;
      d_base_we          = '0;
      d_bound_we         = '0;

      case (state)
         S_POR: state_nx = S_FETCH;

         S_IDLE: begin
            set_clk_enable = 1'b1;
            busy           = 1'b0;
            if (i_miss || (d_access && (&d_miss))) state_nx = S_SEL;
         end

         S_SEL: begin
            if (target_d && !sel_found)                state_nx = S_IDLE;
            else if (target_d && d_dirty[sel_victim])  state_nx = S_WRBK;
            else                                       state_nx = S_FETCH;
         end

         S_WRBK: begin
            spi.spi_addr_valid = 1'b1;
            spi.spi_write      = 1'b1;
            spi.write_strobe   = 4'hF;
            spi.spi_address    = wb_addr;
            spi.spi_store      = wb_data;
            wb_sel             = victim_oh;
            if (xfer_last) state_nx = S_FETCH;
         end

         S_FETCH: begin
            spi.spi_addr_valid = 1'b1;
            spi.spi_address    = fetch_addr;
            if (xfer_last) state_nx = S_UPD_BASE;
         end

         // The final word's refill pulse is still out on entry; the base
         // write waits one cycle so it strictly follows the last refill.
         S_UPD_BASE: begin
            if (!refill_pulse) begin
               if (target_d) d_base_we = victim_oh;
               else          i_base_we = 1'b1;
               state_nx = S_UPD_BOUND;
            end
         end

         S_UPD_BOUND: begin
            if (target_d) d_bound_we = victim_oh;
            else          i_bound_we = 1'b1;
            state_nx = S_IDLE;
         end

         default: state_nx = S_POR;
      endcase
   end

   // State, counters, page/victim capture and registered refill port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_POR;
         word_cnt       <= '0;
         rr_ptr         <= '0;
         victim         <= '0;
         target_d       <= 1'b0;
         wb_base        <= '0;
         base_buffer    <= '0;
         err_all_locked <= 1'b0;
         refill_pulse   <= 1'b0;
         refill_data    <= '0;
         refill_addr    <= '0;
      end else begin
         // NOTE: non-blocking updates so every register here sees the
         // pre-edge value of the others, independent of statement order.
         state        <= state_nx;
         refill_pulse <= (state == S_FETCH) && spi.spi_ready;

         if ((state == S_FETCH) && spi.spi_ready) begin
            refill_data <= spi.spi_fetch;
            refill_addr <= fetch_addr;
         end

         if (xfer_step) word_cnt <= xfer_last ? '0 : word_cnt + 1'b1;

         case (state)
            S_POR: begin
               base_buffer <= page_base(pc_fetch);
               target_d    <= 1'b0;
            end
            S_IDLE: begin
               if (i_miss)                        target_d <= 1'b0;
               else if (d_access && (&d_miss))    target_d <= 1'b1;
            end
            S_SEL: begin
               if (!target_d) begin
                  base_buffer <= page_base(pc_fetch);
               end else if (sel_found) begin
                  base_buffer <= page_base(data_address);
                  victim      <= sel_victim;
                  wb_base     <= d_way_base[int'(sel_victim)*32 +: 32];
                  rr_ptr      <= (sel_victim == LAST_WAY) ? '0 : sel_victim + VW'(1);
               end else begin
                  err_all_locked <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
